dvi_fb_arbiter: RTL and testbench
=================================

Name: dvi_fb_arbiter

Overview:
- Sequences a single-port framebuffer RAM between three requesters: display scanout, a clear engine, and a host port.
- Priority is display > clear > host.
- Consumes the registered pixel position, sync and visible outputs of the timing generator. Produces pixel data plus sync/DE delayed to match, for the TMDS encoders.
- Display reads are scheduled deterministically: one RAM word holds PIX_PER_WORD pixels, so scanout uses one slot in PIX_PER_WORD during the active area. All other slots are free for clear and host traffic.

Parameters:
- DATA_W, 32, RAM word width.
- PIX_W, 8, pixel width. PIX_PER_WORD = DATA_W/PIX_W = 4; must be a power of two.
- FB_ADDR_W, 17, RAM word address width.
- FB_WORDS, 76800, words in frame = SCREEN_H_RES*SCREEN_V_RES/PIX_PER_WORD.

Ports:
- clk_i  in  1  pixel clock
- rst_i  in  1  reset, asynchronous, active-high
- pixel_x_i  in  X_POS_W  current x from sync generator
- pixel_y_i  in  Y_POS_W  current y
- visible_i  in  1  active area flag
- hsync_i, vsync_i  in  1 each  syncs, active-low
- ram_addr_o  out  FB_ADDR_W  RAM address
- ram_we_o  out  1  RAM write enable
- ram_wdata_o  out  DATA_W  RAM write data
- ram_rdata_i  in  DATA_W  RAM read data, valid 1 cycle after address
- host_valid_i  in  1  host request
- host_ready_o  out  1  host grant
- host_we_i  in  1  1 = write, 0 = read
- host_addr_i  in  FB_ADDR_W  host word address
- host_wdata_i  in  DATA_W  host write data
- host_rvalid_o  out  1  read data valid
- host_rdata_o  out  DATA_W  read data
- clear_req_i  in  1  start clear (pulse or level)
- clear_value_i  in  DATA_W  fill word, sampled at clear start
- clear_busy_o  out  1  clear in progress
- clear_done_o  out  1  one-cycle pulse at completion
- pixel_o  out  PIX_W  pixel to encoder
- de_o  out  1  data enable
- hsync_o, vsync_o  out  1 each  delayed syncs

Behaviour:
- Reset, async: pixel_o=0, de_o=0, hsync_o=1, vsync_o=1, host_rvalid_o=0, host_rdata_o=0, clear_busy_o=0, clear_done_o=0, ram_we_o=0, ram_addr_o=0. Clear FSM goes to IDLE.
- Display slot: visible_i && pixel_x_i[log2(PIX_PER_WORD)-1:0]==0.
  - ram_addr_o = pixel_y_i*STRIDE + (pixel_x_i>>log2(PIX_PER_WORD)), where STRIDE = SCREEN_H_RES/PIX_PER_WORD.
  - No multiplier; use shift-add (640: (y<<7)+(y<<5)).
  - ram_we_o=0.
- Display pipeline, fixed latency 2:
  - Cycle t+1: ram_rdata_i captured into the word register.
  - Cycle t+2: pixel_o = lane (x mod PIX_PER_WORD) of that word, lane 0 = bits [PIX_W-1:0].
  - de_o, hsync_o, vsync_o are visible_i, hsync_i, vsync_i delayed exactly 2 cycles.
  - pixel_o=0 whenever de_o=0.
- Non-display slot: clear FSM if busy, else host.
  - host_ready_o = !display_slot && clear FSM IDLE. Combinational from inputs and state.
  - With cfg fixed, the host is stalled at most 1 cycle in 4 during active and never in blanking.
- Host transfer when host_valid_i && host_ready_o.
  - Write: ram_we_o=1 with host address/data.
  - Read: host_rvalid_o=1 exactly 1 cycle later, host_rdata_o = ram_rdata_i registered-through.
  - host_rvalid_o is a one-cycle pulse per accepted read.
  - Reads are pipelined back-to-back, one per cycle.
- host_addr_i >= FB_WORDS: request is accepted. A write is dropped (ram_we_o=0). A read returns host_rvalid_o=1 with host_rdata_o=0.
- Clear FSM:
  - IDLE --clear_req_i--> FILL: latch clear_value_i, addr counter=0, clear_busy_o=1.
  - FILL: on each non-display slot, write the latched value at the counter, then increment.
  - FILL → DONE when a write to FB_WORDS-1 occurs.
  - DONE: clear_done_o=1 for one cycle, busy=0, → IDLE.
- clear_req_i while in FILL/DONE is ignored.
- A host request pending at clear start stays unacknowledged, with ready=0, until IDLE.
- A clear spanning vsync is legal; scanout may show a partially cleared frame.
- Simultaneous host_valid and clear_req in the same IDLE cycle: the host is granted that cycle (ready computed from the current state), and the FSM enters FILL next cycle.
- When no requester owns a slot: ram_we_o=0, ram_addr_o holds its previous value.

Decomposition:
- Add to dvi_pkg: PIX_W, DATA_W, PIX_PER_WORD, FB_WORDS, FB_ADDR_W, STRIDE, and the clear FSM state enum.
- One sub-module, dvi_fb_clear: the clear FSM plus address counter, with a slot-available input, and write strobe/address/data outputs.
- The arbiter top holds the slot decode, address computation, host path and display pipeline.

Test Plan:
1. Display pipeline: preload word 0 = 0x44332211 and drive x=0..3, y=0, visible=1 → pixel_o = 0x11, 0x22, 0x33, 0x44 on cycles 2..5, with de_o=1 aligned. With x=4, y=1, ram_addr_o = 161.
2. Host stall: hold host_valid_i=1 (writes) through the active line → host_ready_o low exactly on cycles with x%4==0. All other writes land at the given addresses. No grant lost.
3. Host reads in blanking: 3 back-to-back reads of addr 5, 6, 7 → host_rvalid_o high on 3 consecutive cycles, one cycle after each grant, with the matching data.
4. Clear: pulse clear_req_i, value 0xA5A5A5A5 → clear_busy_o=1 next cycle and every address 0..76799 is written. clear_done_o pulses once, and host_ready_o=0 throughout. A second clear_req mid-fill has no effect.
5. Out-of-range: host write to addr 76800 → ram_we_o stays 0. A read to the same address → rvalid=1 with rdata=0.
6. Async reset asserted mid-clear and mid-line → all outputs take reset values immediately and the FSM returns to IDLE. After release, the first display word appears 2 cycles after the next slot.

Source files
------------

// File: rtl/dvi_pkg.sv
// Shared framebuffer geometry, widths and clear FSM states for the DVI
// framebuffer arbiter.
package dvi_pkg;

  localparam int SCREEN_H_RES = 640;
  localparam int SCREEN_V_RES = 480;
  localparam int X_POS_W      = 10;
  localparam int Y_POS_W      = 10;

  localparam int DATA_W       = 32;
  localparam int PIX_W        = 8;
  localparam int PIX_PER_WORD = DATA_W / PIX_W;
  localparam int PIX_SEL_W    = $clog2(PIX_PER_WORD);

  localparam int FB_ADDR_W    = 17;
  localparam int FB_WORDS     = SCREEN_H_RES * SCREEN_V_RES / PIX_PER_WORD;
  localparam int STRIDE       = SCREEN_H_RES / PIX_PER_WORD;

  typedef enum logic [1:0] {
    CLR_IDLE,
    CLR_FILL,
    CLR_DONE
  } clr_state_e;

  // Row base address y*STRIDE; STRIDE = 160 = 128 + 32, so two shifts and an add.
  function automatic logic [FB_ADDR_W-1:0] row_base(input logic [Y_POS_W-1:0] y);
    logic [FB_ADDR_W-1:0] yw;
    yw = FB_ADDR_W'(y);
    return (yw << 7) + (yw << 5);
  endfunction

endpackage

// File: rtl/dvi_fb_clear.sv
// Clear engine: walks the whole framebuffer writing one latched fill word
// into each slot the arbiter offers, then pulses done.
module dvi_fb_clear
  import dvi_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_req_i,
  input  logic [DATA_W-1:0]    clear_value_i,
  input  logic                 slot_avail_i,
  output logic                 idle_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 wr_o,
  output logic [FB_ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0]    wr_data_o
);

  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(FB_WORDS - 1);

  clr_state_e           state_q, state_d;
  logic [FB_ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]    val_q, val_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    val_d     = val_q;
    wr_o      = 1'b0;
    idle_o    = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    wr_addr_o = cnt_q;
    wr_data_o = val_q;
    case (state_q)
      CLR_IDLE: begin
        idle_o = 1'b1;
        if (clear_req_i) begin
          state_d = CLR_FILL;
          cnt_d   = '0;
          val_d   = clear_value_i;
        end
      end
      CLR_FILL: begin
        busy_o = 1'b1;
        if (slot_avail_i) begin
          wr_o = 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_d = CLR_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      CLR_DONE: begin
        done_o  = 1'b1;
        state_d = CLR_IDLE;
      end
      default: state_d = CLR_IDLE;
    endcase
  end

endmodule

// File: rtl/dvi_fb_arbiter.sv
// Single-port framebuffer sequencer: scanout owns one slot per word of pixels,
// remaining slots go to the clear engine when busy, otherwise to the host.
module dvi_fb_arbiter
  import dvi_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [X_POS_W-1:0]   pixel_x_i,
  input  logic [Y_POS_W-1:0]   pixel_y_i,
  input  logic                 visible_i,
  input  logic                 hsync_i,
  input  logic                 vsync_i,
  output logic [FB_ADDR_W-1:0] ram_addr_o,
  output logic                 ram_we_o,
  output logic [DATA_W-1:0]    ram_wdata_o,
  input  logic [DATA_W-1:0]    ram_rdata_i,
  input  logic                 host_valid_i,
  output logic                 host_ready_o,
  input  logic                 host_we_i,
  input  logic [FB_ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0]    host_wdata_i,
  output logic                 host_rvalid_o,
  output logic [DATA_W-1:0]    host_rdata_o,
  input  logic                 clear_req_i,
  input  logic [DATA_W-1:0]    clear_value_i,
  output logic                 clear_busy_o,
  output logic                 clear_done_o,
  output logic [PIX_W-1:0]     pixel_o,
  output logic                 de_o,
  output logic                 hsync_o,
  output logic                 vsync_o
);

  logic                 display_slot;
  logic [FB_ADDR_W-1:0] disp_addr;
  logic                 host_in_range;
  logic                 host_fire;
  logic                 clr_idle, clr_wr;
  logic [FB_ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0]    clr_data;

  logic [FB_ADDR_W-1:0] addr_q, addr_d;
  logic                 we_d;
  logic [DATA_W-1:0]    wdata_d;

  logic                 rvalid_q, rzero_q;

  logic                 vis_q1, hs_q1, vs_q1, slot_q1;
  logic [PIX_SEL_W-1:0] lane_q1;
  logic [DATA_W-1:0]    word_q, word_src;
  logic                 de_q, hs_q, vs_q;
  logic [PIX_W-1:0]     pix_q;

  assign display_slot  = visible_i && (pixel_x_i[PIX_SEL_W-1:0] == '0);
  assign disp_addr     = row_base(pixel_y_i) + FB_ADDR_W'(pixel_x_i >> PIX_SEL_W);
  assign host_in_range = host_addr_i < FB_ADDR_W'(FB_WORDS);
  assign host_ready_o  = !display_slot && clr_idle;
  assign host_fire     = host_valid_i && host_ready_o;

  dvi_fb_clear u_clear (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clear_req_i   (clear_req_i),
    .clear_value_i (clear_value_i),
    .slot_avail_i  (!display_slot),
    .idle_o        (clr_idle),
    .busy_o        (clear_busy_o),
    .done_o        (clear_done_o),
    .wr_o          (clr_wr),
    .wr_addr_o     (clr_addr),
    .wr_data_o     (clr_data)
  );

  // Out-of-range host accesses never reach the RAM; the address simply holds.
  always_comb begin
    addr_d  = addr_q;
    we_d    = 1'b0;
    wdata_d = '0;
    if (display_slot) begin
      addr_d = disp_addr;
    end else if (clr_wr) begin
      addr_d  = clr_addr;
      we_d    = 1'b1;
      wdata_d = clr_data;
    end else if (host_fire && host_in_range) begin
      addr_d  = host_addr_i;
      we_d    = host_we_i;
      wdata_d = host_wdata_i;
    end
  end

  // RAM address is combinational so read data lines up one cycle later;
  // reset forces it quiet without waiting for a clock.
  assign ram_addr_o  = rst_i ? '0 : addr_d;
  assign ram_we_o    = !rst_i && we_d;
  assign ram_wdata_o = wdata_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q   <= '0;
      rvalid_q <= 1'b0;
      rzero_q  <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      rvalid_q <= host_fire && !host_we_i;
      rzero_q  <= !host_in_range;
    end
  end

  assign host_rvalid_o = rvalid_q;
  assign host_rdata_o  = (rvalid_q && !rzero_q) ? ram_rdata_i : '0;

  // The first lane of a word is taken straight off the RAM bus; later lanes
  // come from the word register captured in that same cycle.
  assign word_src = slot_q1 ? ram_rdata_i : word_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vis_q1  <= 1'b0;
      hs_q1   <= 1'b1;
      vs_q1   <= 1'b1;
      slot_q1 <= 1'b0;
      lane_q1 <= '0;
      word_q  <= '0;
      de_q    <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      pix_q   <= '0;
    end else begin
      vis_q1  <= visible_i;
      hs_q1   <= hsync_i;
      vs_q1   <= vsync_i;
      slot_q1 <= display_slot;
      lane_q1 <= pixel_x_i[PIX_SEL_W-1:0];
      word_q  <= word_src;
      de_q    <= vis_q1;
      hs_q    <= hs_q1;
      vs_q    <= vs_q1;
      pix_q   <= vis_q1 ? word_src[lane_q1*PIX_W +: PIX_W] : '0;
    end
  end

  assign pixel_o = pix_q;
  assign de_o    = de_q;
  assign hsync_o = hs_q;
  assign vsync_o = vs_q;

endmodule

// File: tb/tb_dvi_fb_arbiter.sv
// Scoreboard bench for dvi_fb_arbiter: a framebuffer reference model predicts
// per-cycle grants, RAM traffic, read returns and pixels; a monitor compares.
module tb_dvi_fb_arbiter;
  import dvi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [X_POS_W-1:0]   pixel_x;
  logic [Y_POS_W-1:0]   pixel_y;
  logic                 visible, hsync, vsync;
  logic [FB_ADDR_W-1:0] ram_addr_o;
  logic                 ram_we_o;
  logic [DATA_W-1:0]    ram_wdata_o;
  logic [DATA_W-1:0]    ram_rdata;
  logic                 host_valid, host_ready_o, host_we;
  logic [FB_ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0]    host_wdata;
  logic                 host_rvalid_o;
  logic [DATA_W-1:0]    host_rdata_o;
  logic                 clear_req;
  logic [DATA_W-1:0]    clear_value;
  logic                 clear_busy_o, clear_done_o;
  logic [PIX_W-1:0]     pixel_o;
  logic                 de_o, hsync_o, vsync_o;

  dvi_fb_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .pixel_x_i(pixel_x), .pixel_y_i(pixel_y), .visible_i(visible),
    .hsync_i(hsync), .vsync_i(vsync),
    .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata),
    .host_valid_i(host_valid), .host_ready_o(host_ready_o), .host_we_i(host_we),
    .host_addr_i(host_addr), .host_wdata_i(host_wdata),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
    .clear_req_i(clear_req), .clear_value_i(clear_value),
    .clear_busy_o(clear_busy_o), .clear_done_o(clear_done_o),
    .pixel_o(pixel_o), .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o)
  );

  typedef struct {
    int cyc; bit rdy; bit busy; bit done; bit slot; logic [16:0] daddr;
    bit cwr; logic [16:0] caddr; logic [31:0] cdata;
  } ce_t;
  typedef struct { int cyc; logic [16:0] addr; logic [31:0] data; } xfer_t;
  typedef struct { int cyc; bit de; bit hs; bit vs; logic [7:0] pix; } px_t;

  ce_t   ce_q[$];
  xfer_t wr_q[$];
  xfer_t rd_q[$];
  px_t   px_q[$];

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;

  function automatic logic [31:0] seed(input int i);
    logic [31:0] v;
    v = 32'(i) * 32'h9E3779B1;
    return v ^ 32'h5BD1E995;
  endfunction

  // Framebuffer RAM with one-cycle read latency.
  logic [31:0] mem [FB_WORDS];
  bit mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < FB_WORDS; i++) mem[i] <= seed(i);
      mem_init <= 1'b1;
    end else if (ram_we_o && int'(ram_addr_o) < FB_WORDS) begin
      mem[ram_addr_o] <= ram_wdata_o;
    end
    ram_rdata <= (int'(ram_addr_o) < FB_WORDS) ? mem[ram_addr_o] : 32'h0;
  end

  // Reference model: expected framebuffer contents and clear progress.
  logic [31:0] ref_mem [FB_WORDS];
  int          mst = 0;
  int          clr_idx = 0;
  logic [31:0] clr_val = 32'h0;
  logic [31:0] cur_word = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input bit vis, input int x, input int y, input bit hs, input bit vs,
                       input bit hv, input bit hwe, input int haddr, input logic [31:0] hwd,
                       input bit creq, input logic [31:0] cval);
    ce_t   e;
    px_t   p;
    xfer_t t;
    bit    slot;
    int    nmst;
    visible = vis; pixel_x = 10'(x); pixel_y = 10'(y); hsync = hs; vsync = vs;
    host_valid = hv; host_we = hwe; host_addr = 17'(haddr); host_wdata = hwd;
    clear_req = creq; clear_value = cval;

    slot    = vis && (x % PIX_PER_WORD == 0);
    e.cyc   = cyc; e.slot = slot; e.daddr = 17'(y * STRIDE + x / PIX_PER_WORD);
    e.rdy   = !slot && (mst == 0);
    e.busy  = (mst == 1); e.done = (mst == 2);
    e.cwr   = 1'b0; e.caddr = '0; e.cdata = '0;

    if (slot) cur_word = ref_mem[y * STRIDE + x / PIX_PER_WORD];
    p.cyc = cyc + 2; p.de = vis; p.hs = hs; p.vs = vs;
    p.pix = vis ? cur_word[8 * (x % PIX_PER_WORD) +: 8] : 8'h00;

    if (hv && e.rdy) begin
      t.cyc = hwe ? cyc : cyc + 1;
      t.addr = 17'(haddr);
      if (hwe) begin
        if (haddr < FB_WORDS) begin
          t.data = hwd;
          ref_mem[haddr] = hwd;
          wr_q.push_back(t);
        end
      end else begin
        t.data = (haddr < FB_WORDS) ? ref_mem[haddr] : 32'h0;
        rd_q.push_back(t);
      end
    end

    nmst = mst;
    case (mst)
      0: if (creq) begin nmst = 1; clr_val = cval; clr_idx = 0; end
      1: if (!slot) begin
        e.cwr = 1'b1; e.caddr = 17'(clr_idx); e.cdata = clr_val;
        ref_mem[clr_idx] = clr_val;
        clr_idx++;
        if (clr_idx == FB_WORDS) nmst = 2;
      end
      default: nmst = 0;
    endcase
    mst = nmst;
    ce_q.push_back(e);
    px_q.push_back(p);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic blank(input bit hv, input bit hwe, input int a, input logic [31:0] d);
    drive(1'b0, 0, 0, 1'($urandom % 2), 1'($urandom % 2), hv, hwe, a, d, 1'b0, 32'h0);
    tick();
  endtask

  task automatic check_reset_outputs();
    chk("rst_pixel", pixel_o, 0);
    chk("rst_de", de_o, 0);
    chk("rst_hsync", hsync_o, 1);
    chk("rst_vsync", vsync_o, 1);
    chk("rst_rvalid", host_rvalid_o, 0);
    chk("rst_rdata", host_rdata_o, 0);
    chk("rst_busy", clear_busy_o, 0);
    chk("rst_done", clear_done_o, 0);
    chk("rst_we", ram_we_o, 0);
    chk("rst_addr", ram_addr_o, 0);
  endtask

  // Monitor: pops whatever the model scheduled for this cycle and compares.
  ce_t   m_e;
  xfer_t m_t;
  px_t   m_p;
  always @(negedge clk) begin
    while (ce_q.size() > 0 && ce_q[0].cyc < cyc) void'(ce_q.pop_front());
    while (px_q.size() > 0 && px_q[0].cyc < cyc) void'(px_q.pop_front());
    while (wr_q.size() > 0 && wr_q[0].cyc < cyc) void'(wr_q.pop_front());
    while (rd_q.size() > 0 && rd_q[0].cyc < cyc) void'(rd_q.pop_front());
    if (!rst) begin
      if (clear_done_o) n_done++;
      if (ce_q.size() > 0 && ce_q[0].cyc == cyc) begin
        m_e = ce_q.pop_front();
        chk("host_ready", host_ready_o, m_e.rdy);
        chk("clear_busy", clear_busy_o, m_e.busy);
        chk("clear_done", clear_done_o, m_e.done);
        if (m_e.slot) begin
          chk("disp_addr", ram_addr_o, m_e.daddr);
          chk("disp_we", ram_we_o, 0);
        end else if (m_e.cwr) begin
          chk("clr_we", ram_we_o, 1);
          chk("clr_addr", ram_addr_o, m_e.caddr);
          chk("clr_data", ram_wdata_o, m_e.cdata);
        end else if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
          m_t = wr_q.pop_front();
          chk("host_we", ram_we_o, 1);
          chk("host_waddr", ram_addr_o, m_t.addr);
          chk("host_wdata", ram_wdata_o, m_t.data);
        end else begin
          chk("idle_we", ram_we_o, 0);
        end
      end
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
        m_t = rd_q.pop_front();
        chk("rvalid", host_rvalid_o, 1);
        chk("rdata", host_rdata_o, m_t.data);
      end else begin
        chk("rvalid_idle", host_rvalid_o, 0);
      end
      if (px_q.size() > 0 && px_q[0].cyc == cyc) begin
        m_p = px_q.pop_front();
        chk("de", de_o, m_p.de);
        chk("hsync", hsync_o, m_p.hs);
        chk("vsync", vsync_o, m_p.vs);
        chk("pixel", pixel_o, m_p.pix);
      end
    end
  end

  initial begin
    int guard;
    int bad;
    bit vis;
    for (int i = 0; i < FB_WORDS; i++) ref_mem[i] = seed(i);
    rst = 1'b1;
    visible = 0; pixel_x = '0; pixel_y = '0; hsync = 1; vsync = 1;
    host_valid = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    clear_req = 0; clear_value = '0;
    #1;
    check_reset_outputs();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;

    // Preload the words scanned out below, then random host writes in blanking.
    blank(1, 1, 0, 32'h44332211);
    blank(1, 1, 161, 32'hDDCCBBAA);
    for (int i = 0; i < 20; i++) blank(1, 1, 1000 + int'($urandom % 60000), $urandom);

    // Two active lines with host traffic competing for the free slots.
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < 64; x++) begin
        drive(1, x, y, 1, 1, 1'($urandom % 4 != 0), 1'($urandom % 2),
              1000 + int'($urandom % 60000), $urandom, 0, 32'h0);
        if (y == 1 && x == 4) begin
          #1;
          chk("addr_x4_y1", ram_addr_o, 161);
        end
        tick();
      end
      for (int i = 0; i < 8; i++) blank(1, 1'($urandom % 2), 1000 + int'($urandom % 60000), $urandom);
    end

    // Back-to-back reads in blanking.
    blank(1, 0, 5, 0);
    blank(1, 0, 6, 0);
    blank(1, 0, 7, 0);
    blank(0, 0, 0, 0);

    // Out-of-range accesses.
    blank(1, 1, FB_WORDS, 32'hDEADBEEF);
    blank(1, 0, FB_WORDS, 0);
    blank(1, 1, 131071, 32'hCAFEF00D);
    blank(1, 0, 131071, 0);
    blank(1, 0, 0, 0);
    blank(0, 0, 0, 0);

    // Clear requested in the same cycle as a host write; a second request mid-fill.
    n_done = 0;
    drive(0, 0, 0, 1, 1, 1, 1, 3000, $urandom, 1, 32'hA5A5A5A5);
    tick();
    guard = 0;
    while (mst != 0 && guard < 80000) begin
      vis = (guard < 256) && ((guard % 128) < 64);
      drive(vis, vis ? guard % 128 : 0, 479, 1, 1, 1, 1'($urandom % 2),
            1000 + int'($urandom % 60000), $urandom, guard == 100, 32'h5A5A5A5A);
      tick();
      guard++;
    end
    if (guard >= 80000) begin
      n_vec++; n_err++;
      $display("FAIL clear_timeout cyc=%0d actual=%0d required<%0d", cyc, guard, 80000);
    end
    blank(0, 0, 0, 0);
    blank(0, 0, 0, 0);
    chk("clear_done_pulses", n_done, 1);
    for (int i = 0; i < 8; i++) blank(1, 0, int'($urandom % FB_WORDS), 0);
    blank(0, 0, 0, 0);

    // Async reset while a clear runs and a line is being scanned.
    drive(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 32'h0F0F0F0F);
    tick();
    for (int x = 0; x < 29; x++) begin
      drive(1, x, 2, 1, 1, 0, 0, 0, 0, 0, 32'h0);
      if (x == 28) begin
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        ce_q.delete(); px_q.delete(); wr_q.delete(); rd_q.delete();
        mst = 0;
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 32'h0);
      tick();
    end
    rst = 1'b0;
    blank(1, 1, 2000, 32'h12345678);
    for (int x = 0; x < 32; x++) begin
      drive(1, x, 0, 1, 1, 1'($urandom % 2), 1, 1000 + int'($urandom % 60000), $urandom, 0, 32'h0);
      tick();
    end
    for (int i = 0; i < 4; i++) blank(0, 0, 0, 0);

    bad = 0;
    for (int i = 0; i < FB_WORDS; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("fb_contents", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
